// File: rtl/regfile_wb_arbiter.sv
// Write-back scheduler sharing the register file's single write port between the ALU and load paths.
// Define RF_WB_BYPASS_EN to add the read-port bypass of the pending write.
module regfile_wb_arbiter #(
    parameter int MAX_WAIT = 3,
    parameter int CW       = $clog2(MAX_WAIT + 1)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
`ifdef RF_WB_BYPASS_EN
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [31:0] rf_rd1,
    input  logic [31:0] rf_rd2,
    output logic [31:0] byp_rd1,
    output logic [31:0] byp_rd2,
`endif
    output logic        WE3,
    output logic [4:0]  A3,
    output logic [31:0] WD3,
    output logic        last_src
);

    localparam logic [CW-1:0] AGE_MAX = CW'(MAX_WAIT);

    logic [CW-1:0] age_cnt;
    logic          alu_forced;
    logic          accept;
    logic [4:0]    sel_rd;
    logic [31:0]   sel_data;

    // Handshake: a transfer happens on a cycle where valid && ready. A requester
    // holds valid, rd and data stable until it sees ready; ready is a function of
    // the two valids, stall and the aging counter only, and at most one is high.
    assign alu_forced = (age_cnt == AGE_MAX);

    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (!stall) begin
            if (alu_valid && (!mem_valid || alu_forced)) begin
                alu_ready = 1'b1;
            end else if (mem_valid) begin
                mem_ready = 1'b1;
            end
        end
    end

    assign accept   = alu_ready | mem_ready;
    assign sel_rd   = mem_ready ? mem_rd   : alu_rd;
    assign sel_data = mem_ready ? mem_data : alu_data;

    // Counts cycles the ALU is refused while MEM wins; frozen during stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age_cnt <= '0;
        end else if (!stall) begin
            if (!alu_valid || alu_ready) begin
                age_cnt <= '0;
            end else if (age_cnt != AGE_MAX) begin
                age_cnt <= age_cnt + CW'(1);
            end
        end
    end

    // Writes to x0 are accepted and recorded in last_src but never reach the port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WE3      <= 1'b0;
            A3       <= '0;
            WD3      <= '0;
            last_src <= 1'b0;
        end else begin
            WE3 <= accept && (sel_rd != 5'd0);
            if (accept && (sel_rd != 5'd0)) begin
                A3  <= sel_rd;
                WD3 <= sel_data;
            end
            if (accept) begin
                last_src <= mem_ready;
            end
        end
    end

`ifdef RF_WB_BYPASS_EN
    // The register file only latches WD3 on the next edge, so forward it to readers now.
    assign byp_rd1 = (WE3 && (A3 == ra1) && (ra1 != 5'd0)) ? WD3 : rf_rd1;
    assign byp_rd2 = (WE3 && (A3 == ra2) && (ra2 != 5'd0)) ? WD3 : rf_rd2;
`endif

    one_ready_a : assert property (@(posedge clk) disable iff (!rst) !(alu_ready && mem_ready));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: driver checks readies, scoreboard checks the write port.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_rd = '0;
  logic [31:0] mem_data = '0;
  logic        alu_ready, mem_ready, WE3, last_src;
  logic [4:0]  A3;
  logic [31:0] WD3;
`ifdef RF_WB_BYPASS_EN
  logic [4:0]  ra1 = '0, ra2 = '0;
  logic [31:0] rf_rd1 = '0, rf_rd2 = '0;
  logic [31:0] byp_rd1, byp_rd2;
`endif

  int n_checks = 0;
  int n_fail = 0;
  // {we, a3[4:0], wd3[31:0], last_src}
  logic [38:0] exp_q[$];
  logic acc_d = 1'b0;

  regfile_wb_arbiter #(.MAX_WAIT(3)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
`ifdef RF_WB_BYPASS_EN
    .ra1(ra1), .ra2(ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .byp_rd1(byp_rd1), .byp_rd2(byp_rd2),
`endif
    .WE3(WE3), .A3(A3), .WD3(WD3), .last_src(last_src)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [38:0] wb(input logic we, input logic [4:0] a, input logic [31:0] d,
                                     input logic s);
    return {we, a, d, s};
  endfunction

  // driver: one cycle of stimulus, ready check, expected write-back pushed on accept
  task automatic cyc(input logic st, input logic av, input logic [4:0] ard, input logic [31:0] adat,
                     input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                     input logic exp_ar, input logic exp_mr, input logic [38:0] exp_wb);
    @(posedge clk);
    #1;
    stall = st;
    alu_valid = av; alu_rd = ard; alu_data = adat;
    mem_valid = mv; mem_rd = mrd; mem_data = mdat;
    @(negedge clk);
    check("alu_ready", {31'd0, alu_ready}, {31'd0, exp_ar});
    check("mem_ready", {31'd0, mem_ready}, {31'd0, exp_mr});
    if (exp_ar || exp_mr) exp_q.push_back(exp_wb);
  endtask

  // scoreboard monitor: the cycle after any accept, the write port must match the queue head
  always @(negedge clk) begin
    if (!rst) begin
      acc_d <= 1'b0;
      exp_q.delete();
    end else begin
      if (acc_d) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          check("wb_we3", {31'd0, WE3}, {31'd0, exp_q[0][38]});
          check("wb_a3", {27'd0, A3}, {27'd0, exp_q[0][37:33]});
          check("wb_wd3", WD3, exp_q[0][32:1]);
          check("wb_last_src", {31'd0, last_src}, {31'd0, exp_q[0][0]});
          void'(exp_q.pop_front());
        end
      end else begin
        check("we3_idle", {31'd0, WE3}, 32'd0);
      end
      acc_d <= alu_ready | mem_ready;
    end
  end

  initial begin
    // reset held with both requesters active
    rst = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h44;
    repeat (2) @(negedge clk);
    check("rst_we3", {31'd0, WE3}, 32'd0);
    check("rst_a3", {27'd0, A3}, 32'd0);
    check("rst_wd3", WD3, 32'd0);
    check("rst_last_src", {31'd0, last_src}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rel_alu_ready", {31'd0, alu_ready}, 32'd0);
    check("rel_mem_ready", {31'd0, mem_ready}, 32'd1);
    exp_q.push_back(wb(1'b1, 5'd4, 32'h44, 1'b1));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);

    // single ALU write
    cyc(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 1, 0, wb(1'b1, 5'd5, 32'hDEADBEEF, 1'b0));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);

    // contention: MEM wins three times, then the aged ALU request is forced through
    cyc(0, 1, 5'd9, 32'h99, 1, 5'd1, 32'h101, 0, 1, wb(1'b1, 5'd1, 32'h101, 1'b1));
    cyc(0, 1, 5'd9, 32'h99, 1, 5'd2, 32'h102, 0, 1, wb(1'b1, 5'd2, 32'h102, 1'b1));
    cyc(0, 1, 5'd9, 32'h99, 1, 5'd3, 32'h103, 0, 1, wb(1'b1, 5'd3, 32'h103, 1'b1));
    cyc(0, 1, 5'd9, 32'h99, 1, 5'd4, 32'h104, 1, 0, wb(1'b1, 5'd9, 32'h99, 1'b0));
    cyc(0, 0, 0, 0, 1, 5'd4, 32'h104, 0, 1, wb(1'b1, 5'd4, 32'h104, 1'b1));

    // ALU write then a load to x0: port holds A3/WD3, last_src moves to MEM
    cyc(0, 1, 5'd10, 32'hAAAA0000, 0, 0, 0, 1, 0, wb(1'b1, 5'd10, 32'hAAAA0000, 1'b0));
    cyc(0, 0, 0, 0, 1, 5'd0, 32'h1234, 0, 1, wb(1'b0, 5'd10, 32'hAAAA0000, 1'b1));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);

    // stall freezes the aging counter at 1, so MEM still wins twice after it
    cyc(0, 1, 5'd12, 32'hC12, 1, 5'd13, 32'hD13, 0, 1, wb(1'b1, 5'd13, 32'hD13, 1'b1));
    repeat (4) cyc(1, 1, 5'd12, 32'hC12, 1, 5'd14, 32'hD14, 0, 0, '0);
    cyc(0, 1, 5'd12, 32'hC12, 1, 5'd14, 32'hD14, 0, 1, wb(1'b1, 5'd14, 32'hD14, 1'b1));
    cyc(0, 1, 5'd12, 32'hC12, 1, 5'd15, 32'hD15, 0, 1, wb(1'b1, 5'd15, 32'hD15, 1'b1));
    cyc(0, 1, 5'd12, 32'hC12, 1, 5'd16, 32'hD16, 1, 0, wb(1'b1, 5'd12, 32'hC12, 1'b0));
    cyc(0, 0, 0, 0, 1, 5'd16, 32'hD16, 0, 1, wb(1'b1, 5'd16, 32'hD16, 1'b1));

    // same destination from both sources in successive cycles
    cyc(0, 1, 5'd21, 32'h2101, 0, 0, 0, 1, 0, wb(1'b1, 5'd21, 32'h2101, 1'b0));
    cyc(0, 0, 0, 0, 1, 5'd21, 32'h2102, 0, 1, wb(1'b1, 5'd21, 32'h2102, 1'b1));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);

`ifdef RF_WB_BYPASS_EN
    cyc(0, 1, 5'd7, 32'hA5A5A5A5, 0, 0, 0, 1, 0, wb(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0));
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    ra1 = 5'd7; rf_rd1 = 32'd0; ra2 = 5'd0; rf_rd2 = 32'h1111;
    @(negedge clk);
    check("byp_rd1_fwd", byp_rd1, 32'hA5A5A5A5);
    check("byp_rd2_x0", byp_rd2, 32'h1111);
    @(posedge clk);
    #1;
    rf_rd1 = 32'h2222;
    @(negedge clk);
    check("byp_rd1_nowe", byp_rd1, 32'h2222);
`endif

    // reset between accept and write drops the write
    cyc(0, 1, 5'd20, 32'h20, 0, 0, 0, 1, 0, wb(1'b1, 5'd20, 32'h20, 1'b0));
    #1;
    rst = 1'b0;
    alu_valid = 1'b0;
    @(negedge clk);
    check("midrst_we3", {31'd0, WE3}, 32'd0);
    check("midrst_a3", {27'd0, A3}, 32'd0);
    check("midrst_wd3", WD3, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);

    check("sb_drain", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
